// File: rtl/i2c_pkg.sv
// i2c_pkg: command codes, sequencer states and per-quarter bus waveform lookup.
package i2c_pkg;
  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_e;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_Q0   = 3'd1,
    ST_Q1   = 3'd2,
    ST_Q2   = 3'd3,
    ST_Q3   = 3'd4
  } state_e;
  // Returns {scl_oe, sda_oe} for a command in a given quarter; SCL is released in Q1/Q2 for data bits.
  function automatic logic [1:0] wave(input cmd_e c, input logic d, input state_e s);
    logic mid;
    mid = (s == ST_Q1) || (s == ST_Q2);
    case (c)
      CMD_START: wave = {s == ST_Q3, (s == ST_Q2) || (s == ST_Q3)};
      CMD_STOP:  wave = {s == ST_Q0, s != ST_Q3};
      CMD_WRITE: wave = {!mid, !d};
      default:   wave = {!mid, 1'b0};
    endcase
  endfunction
endpackage

// File: rtl/quarter_timer.sv
// quarter_timer: prescale up-counter flagging the last cycle of a quarter.
module quarter_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] limit,
  output logic             full
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  assign full = enable && (cnt_q == limit);
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl: bit-level I2C master sequencer splitting each bus command into four timed quarters.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic             din,
  input  logic [DIV_W-1:0] presc,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             dout,
  output logic             done,
  output logic             busy
);
  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic             din_q, din_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic             dout_q, dout_d, done_q, done_d;
  logic             accept, stretch, full;
  assign cmd_ready = state_q == ST_IDLE;
  assign busy      = state_q != ST_IDLE;
  assign accept    = cmd_valid && cmd_ready;
  // A slave holding SCL low during the high phase freezes the quarter.
  assign stretch   = (state_q == ST_Q1) && (cmd_q != CMD_START) && !scl_in;
  quarter_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (full || accept),
    .enable (busy && !stretch),
    .limit  (presc_q),
    .full   (full)
  );
  always_comb begin
    cmd_d   = accept ? cmd_e'(cmd) : cmd_q;
    din_d   = accept ? din : din_q;
    presc_d = accept ? presc : presc_q;
    state_d = accept ? ST_Q0 : !full ? state_q :
              state_q == ST_Q3 ? ST_IDLE : state_e'(state_q + 3'd1);
    {scl_oe_d, sda_oe_d} = state_d == ST_IDLE ? {scl_oe_q, sda_oe_q} : wave(cmd_d, din_d, state_d);
    dout_d  = (state_q == ST_Q2) && full && (cmd_q == CMD_READ) ? sda_in : dout_q;
    done_d  = (state_q == ST_Q3) && full;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_START;
      din_q    <= 1'b0;
      presc_q  <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      dout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      presc_q  <= presc_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
    end
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;
  assign dout   = dout_q;
  assign done   = done_q;
endmodule

// File: doc/i2c_bit_ctrl.md
Name: i2c_bit_ctrl

Overview:
Bit-level I2C master sequencer that owns the bus-timing prescale counter.
- Accepts one bus command at a time: START, STOP, WRITE bit or READ bit.
- Splits each command into four quarter-phases; each quarter is timed by the counter reaching its full value.
- Drives open-drain SCL/SDA enables and samples SDA for reads.
- Sits between the byte-level I2C engine and the pads.

Parameters:
DIV_W, 16, width of the prescale value and of the quarter counter.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  block can accept a command.
cmd  input  2  command code (see package).
din  input  1  bit to transmit for WRITE.
presc  input  DIV_W  quarter length minus 1, in clk cycles; sampled at accept.
scl_in  input  1  synchronised SCL pad level (clock stretching).
sda_in  input  1  synchronised SDA pad level.
scl_oe  output  1  1 = pull SCL low, 0 = release.
sda_oe  output  1  1 = pull SDA low, 0 = release.
dout  output  1  bit sampled by the last READ.
done  output  1  one-cycle pulse when a command completes.
busy  output  1  high from the cycle after accept until done.

Behaviour:
Reset values:
- scl_oe=0, sda_oe=0 (bus released).
- dout=0, done=0, busy=0, cmd_ready=1.
- State IDLE, counter=0.
- rst mid-command aborts immediately; outputs take reset values on the next edge.

States and acceptance:
- States: IDLE, Q0, Q1, Q2, Q3.
- cmd_ready = (state==IDLE).
- Accept on cmd_valid && cmd_ready: latch cmd, din and presc into cmd_r, din_r and presc_r; go to Q0 with counter=0.
- presc or din changes while busy are ignored.

Quarter timing:
- In Qn the counter increments each cycle.
- full = (counter==presc_r).
- On full: counter clears and state advances Q0->Q1->Q2->Q3->IDLE.
- Each quarter lasts presc_r+1 cycles; presc_r=0 gives 1-cycle quarters.

Clock stretching:
- In Q1 of WRITE, READ and STOP, while scl_in==0 the counter holds and does not advance.
- No stretch check in other quarters or in START.

Waveforms per quarter Q0/Q1/Q2/Q3, as (scl_oe, sda_oe), registered with the state:
- START: (0,0) (0,0) (0,1) (1,1).
- STOP: (1,1) (0,1) (0,1) (0,0).
- WRITE: scl_oe 1,0,0,1; sda_oe = ~din_r in all four quarters.
- READ: scl_oe 1,0,0,1; sda_oe=0 throughout.

READ sampling:
- dout <= sda_in on the cycle where state==Q2 && full.
- dout holds until the next READ sample.

Completion:
- On Q3 && full, the next cycle is IDLE with done=1 for exactly one cycle, busy=0 and cmd_ready=1.
- A new command may be accepted in that same cycle (back-to-back).

IDLE hold:
- In IDLE, scl_oe and sda_oe hold their last values; no glitch between bits.
- Only rst releases the bus.

Latency:
- Accept at edge T gives done high at T+1+4*(presc_r+1) cycles, plus any stretch cycles.

Boundary conditions:
- presc=all-ones is legal and gives the maximum quarter length.
- The counter never wraps past presc_r.

Decomposition:
Package i2c_pkg holds:
- Command codes: CMD_START=2'd0, CMD_STOP=2'd1, CMD_WRITE=2'd2, CMD_READ=2'd3.
- State encoding for IDLE, Q0..Q3.

Sub-module quarter_timer:
- DIV_W-bit up-counter.
- Inputs: clear, enable, limit.
- Output: full.
- Synchronous reset.
- i2c_bit_ctrl drives enable=busy && !stretch and clear=full||accept.

Test Plan:
1. presc=3, WRITE din=0 accepted at T: sda_oe=1 from T+1; scl_oe 1,0,0,1 for 4 cycles each; done pulse at T+17; busy high T+1..T+16.
2. presc=0, START then STOP back-to-back (cmd_valid held, cmd changed on done cycle): (scl_oe,sda_oe) sequence (0,0)(0,0)(0,1)(1,1) then (1,1)(0,1)(0,1)(0,0); done at T+5 and T+10.
3. presc=1, READ with sda_in=1 during Q2 and 0 elsewhere: dout=1 after Q2 end; sda_oe stays 0; done at T+9.
4. presc=1, WRITE with scl_in held 0 for 5 cycles entering Q1: Q1 extends by 5 cycles; done at T+14.
5. rst asserted mid-Q2 of WRITE din=0: next edge scl_oe=0, sda_oe=0, busy=0, cmd_ready=1; no done pulse.
6. cmd_valid while busy with differing presc: not accepted; cmd_ready=0; timing of the current command unchanged.
